tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single-word holding register in front of
// the coax transmitter. A grant is held for a whole frame and followed by an idle gap.
//
// state  | meaning
// IDLE   | no owner; next valid request is granted
// STREAM | owner's words move through the holding register until its Last word is read
// DRAIN  | Last word handed off; waiting for the transmitter to go inactive
// GAP    | counting idle cycles (txActive low) before a new grant
module tx_arbiter #(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0Valid,
    input  logic [9:0] req0Data,
    input  logic       req0Last,
    output logic       req0Ready,
    input  logic       req1Valid,
    input  logic [9:0] req1Data,
    input  logic       req1Last,
    output logic       req1Ready,
    output logic       txDataAvailable,
    output logic [9:0] txData,
    input  logic       txRen,
    input  logic       txActive,
    output logic [1:0] grant,
    output logic       frameDone,
    output logic       underrunErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [8:0] GAP_LEN = 9'(GAP_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_grant;
    logic       r_last_grant;
    logic       r_hold_full;
    logic [9:0] r_hold_data;
    logic       r_last_captured;
    logic       r_seen_active;
    logic       r_tx_active_d;
    logic [7:0] r_gap_cnt;
    logic       r_frame_done;
    logic       r_underrun;

    logic       w_ready0;
    logic       w_ready1;
    logic       w_accept;
    logic [9:0] w_acc_data;
    logic       w_acc_last;
    logic       w_read;
    logic       w_start;
    logic       w_pick1;
    logic       w_drain_exit;
    logic [8:0] w_gap_inc;
    logic       w_frame_done_nxt;
    logic       w_underrun_nxt;

    assign w_ready0     = (r_state == STREAM) & r_grant[0] & ~r_hold_full & ~r_last_captured;
    assign w_ready1     = (r_state == STREAM) & r_grant[1] & ~r_hold_full & ~r_last_captured;
    assign w_accept     = (req0Valid & w_ready0) | (req1Valid & w_ready1);
    assign w_acc_data   = r_grant[1] ? req1Data : req0Data;
    assign w_acc_last   = r_grant[1] ? req1Last : req0Last;
    assign w_read       = txRen & r_hold_full;
    assign w_start      = (r_state == IDLE) & (req0Valid | req1Valid);
    // r_last_grant = 1 means requester 1 owned the previous frame
    assign w_pick1      = req1Valid & (~req0Valid | ~r_last_grant);
    assign w_drain_exit = (r_state == DRAIN) & r_seen_active & ~txActive;
    assign w_gap_inc    = {1'b0, r_gap_cnt} + 9'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_done_nxt = 1'b0;
        w_underrun_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_read && r_last_captured) begin
                    w_state_nxt = DRAIN;
                end
                // transmitter went idle while the frame is still incomplete
                if (!r_last_captured && r_seen_active && r_tx_active_d && !txActive) begin
                    w_underrun_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (w_drain_exit) begin
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = (GAP_LEN == 9'd0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (!txActive && (w_gap_inc == GAP_LEN)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
        end else if (w_start) begin
            r_grant      <= w_pick1 ? 2'b10 : 2'b01;
            r_last_grant <= w_pick1;
        end else if (w_drain_exit) begin
            r_grant      <= 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= 10'd0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= w_acc_data;
        end else if (w_read) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_captured <= 1'b0;
            r_seen_active   <= 1'b0;
            r_tx_active_d   <= 1'b0;
        end else begin
            r_tx_active_d <= txActive;
            if (w_start) begin
                r_last_captured <= 1'b0;
                r_seen_active   <= 1'b0;
            end else begin
                if (w_accept && w_acc_last) begin
                    r_last_captured <= 1'b1;
                end
                if (((r_state == STREAM) || (r_state == DRAIN)) && txActive) begin
                    r_seen_active <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= 8'd0;
        end else if (r_state == GAP) begin
            r_gap_cnt <= txActive ? 8'd0 : w_gap_inc[7:0];
        end else begin
            r_gap_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign req0Ready       = w_ready0;
    assign req1Ready       = w_ready1;
    assign txDataAvailable = r_hold_full;
    assign txData          = r_hold_data;
    assign grant           = r_grant;
    assign frameDone       = r_frame_done;
    assign underrunErr     = r_underrun;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: a vector table for a single frame, then directed
// sequences for contention/gap, underrun, asynchronous reset and back-to-back frames.
module tb_tx_arbiter;

    logic       clk;
    logic       reset;
    logic       req0Valid;
    logic [9:0] req0Data;
    logic       req0Last;
    logic       req0Ready;
    logic       req1Valid;
    logic [9:0] req1Data;
    logic       req1Last;
    logic       req1Ready;
    logic       txDataAvailable;
    logic [9:0] txData;
    logic       txRen;
    logic       txActive;
    logic [1:0] grant;
    logic       frameDone;
    logic       underrunErr;

    int n_checks = 0;
    int n_fail   = 0;

    tx_arbiter #(.GAP_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0Valid      (req0Valid),
        .req0Data       (req0Data),
        .req0Last       (req0Last),
        .req0Ready      (req0Ready),
        .req1Valid      (req1Valid),
        .req1Data       (req1Data),
        .req1Last       (req1Last),
        .req1Ready      (req1Ready),
        .txDataAvailable(txDataAvailable),
        .txData         (txData),
        .txRen          (txRen),
        .txActive       (txActive),
        .grant          (grant),
        .frameDone      (frameDone),
        .underrunErr    (underrunErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [9:0] d0;
        logic       l0;
        logic       ren;
        logic       act;
        logic [1:0] g;
        logic       av;
        logic [9:0] dat;
        logic       r0;
        logic       fd;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0Valid = 1'b0; req0Data = 10'd0; req0Last = 1'b0;
        req1Valid = 1'b0; req1Data = 10'd0; req1Last = 1'b0;
        txRen = 1'b0; txActive = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int frames;
        int reads;
        int unders;
        int w;
        logic act;
        logic hs;
        logic [9:0] rdata;

        //              v0  d0       l0  ren  act  g      av  dat      r0  fd
        tbl[0]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 10'h000, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 10'h3FF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 10'h3FF, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 10'h3FF, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 10'h155, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 10'h3FF, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 10'h3FF, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 10'h155, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 10'h155, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 10'h155, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 10'h155, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 10'h155, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h155, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h155, 1'b0, 1'b0};

        // reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_avail", 32'(txDataAvailable), 32'h0);
        check("rst_data", 32'(txData), 32'h0);
        check("rst_ready0", 32'(req0Ready), 32'h0);
        check("rst_ready1", 32'(req1Ready), 32'h0);
        check("rst_done", 32'(frameDone), 32'h0);
        check("rst_underrun", 32'(underrunErr), 32'h0);

        // single frame from requester 0
        for (int i = 0; i < 15; i++) begin
            req0Valid = tbl[i].v0; req0Data = tbl[i].d0; req0Last = tbl[i].l0;
            txRen = tbl[i].ren; txActive = tbl[i].act;
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("vec%0d_avail", i), 32'(txDataAvailable), 32'(tbl[i].av));
            check($sformatf("vec%0d_data", i), 32'(txData), 32'(tbl[i].dat));
            check($sformatf("vec%0d_ready0", i), 32'(req0Ready), 32'(tbl[i].r0));
            check($sformatf("vec%0d_ready1", i), 32'(req1Ready), 32'h0);
            check($sformatf("vec%0d_done", i), 32'(frameDone), 32'(tbl[i].fd));
            check($sformatf("vec%0d_underrun", i), 32'(underrunErr), 32'h0);
            tick();
        end

        // contention, gap with a txActive blip, then round-robin
        do_reset();
        req0Valid = 1'b1; req0Data = 10'h001; req0Last = 1'b1;
        req1Valid = 1'b1; req1Data = 10'h2AA; req1Last = 1'b1;
        tick();
        check("cont_grant_first", 32'(grant), 32'h1);
        check("cont_ready1_waits", 32'(req1Ready), 32'h0);
        tick();
        req0Valid = 1'b0;
        check("cont_data0", 32'(txData), 32'h001);
        txRen = 1'b1; txActive = 1'b1;
        tick();
        txRen = 1'b0; txActive = 1'b0;
        tick();
        check("cont_done0", 32'(frameDone), 32'h1);
        check("cont_grant_released", 32'(grant), 32'h0);
        for (int k = 0; k <= 28; k++) begin
            txActive = (k == 10);
            check($sformatf("gap_k%0d_grant", k), 32'(grant), (k >= 28) ? 32'h2 : 32'h0);
            if (k < 28) check($sformatf("gap_k%0d_ready1", k), 32'(req1Ready), 32'h0);
            tick();
        end
        check("cont_data1_kept", 32'(txData), 32'h2AA);
        check("cont_avail1", 32'(txDataAvailable), 32'h1);
        req1Valid = 1'b0; txRen = 1'b1; txActive = 1'b1;
        tick();
        txRen = 1'b0; txActive = 1'b0;
        tick();
        check("cont_done1", 32'(frameDone), 32'h1);
        req0Valid = 1'b1; req0Data = 10'h005; req0Last = 1'b1;
        req1Valid = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        check("rr_before_gap_end", 32'(grant), 32'h0);
        tick();
        check("rr_second_contest", 32'(grant), 32'h1);

        // underrun mid-frame
        do_reset();
        req0Valid = 1'b1; req0Data = 10'h011; req0Last = 1'b0;
        tick();
        tick();
        req0Valid = 1'b0; txActive = 1'b1; txRen = 1'b1;
        check("und_data", 32'(txData), 32'h011);
        tick();
        txRen = 1'b0; txActive = 1'b0;
        check("und_no_early", 32'(underrunErr), 32'h0);
        tick();
        check("und_pulse", 32'(underrunErr), 32'h1);
        check("und_grant_kept", 32'(grant), 32'h1);
        tick();
        check("und_single_pulse", 32'(underrunErr), 32'h0);
        check("und_ready_again", 32'(req0Ready), 32'h1);
        req0Valid = 1'b1; req0Data = 10'h022; req0Last = 1'b1;
        tick();
        req0Valid = 1'b0;
        check("und_next_word", 32'(txData), 32'h022);
        check("und_next_avail", 32'(txDataAvailable), 32'h1);
        txActive = 1'b1; txRen = 1'b1;
        tick();
        txActive = 1'b0; txRen = 1'b0;
        tick();
        check("und_done", 32'(frameDone), 32'h1);
        check("und_done_no_err", 32'(underrunErr), 32'h0);

        // asynchronous reset while a word is held
        do_reset();
        req1Valid = 1'b1; req1Data = 10'h0F0; req1Last = 1'b0;
        tick();
        tick();
        check("arst_pre_avail", 32'(txDataAvailable), 32'h1);
        check("arst_pre_grant", 32'(grant), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("arst_avail", 32'(txDataAvailable), 32'h0);
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_data", 32'(txData), 32'h0);
        check("arst_ready1", 32'(req1Ready), 32'h0);
        #2 reset = 1'b1;
        req0Valid = 1'b1; req0Data = 10'h001; req0Last = 1'b1;
        #1;
        check("arst_idle_grant", 32'(grant), 32'h0);
        tick();
        check("arst_req0_wins", 32'(grant), 32'h1);

        // back-to-back frames, Last every 4th word
        do_reset();
        w = 0; reads = 0; frames = 0; unders = 0; act = 1'b0;
        for (int cyc = 0; cyc < 400 && frames < 3; cyc++) begin
            req0Valid = 1'b1;
            req0Data  = 10'(w);
            req0Last  = (w % 4 == 3);
            txRen     = txDataAvailable;
            txActive  = act | txDataAvailable;
            if (underrunErr) unders++;
            if (frameDone) begin
                frames++;
                check($sformatf("b2b_words_at_frame%0d", frames), 32'(reads), 32'(frames * 4));
            end
            hs = req0Ready;
            if (txDataAvailable) begin
                rdata = txData;
                check($sformatf("b2b_word%0d", reads), 32'(rdata), 32'(reads));
                reads++;
                act = (rdata[1:0] != 2'b11);
            end
            tick();
            if (hs) w++;
        end
        check("b2b_frames", 32'(frames), 32'd3);
        check("b2b_reads", 32'(reads), 32'd12);
        check("b2b_no_underrun", 32'(unders), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
